// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The reset value should match the idle level of the line being synchronized.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver: mid-bit sampling timed by a per-bit cycle counter,
// one-cycle valid / frame_err strobes, data held until the next good frame.
module receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_s;

  sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e          state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [7:0]           data_d;
  logic                 armed, armed_d;
  logic                 valid_d, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shift     <= shift_d;
      armed     <= armed_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shift_d     = shift;
    armed_d     = armed;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state)
      IDLE: begin
        // A line still low after a frame (break) must go high before it can
        // start another frame; armed records that it has.
        if (rx_s == IDLE_LEVEL) begin
          armed_d = 1'b1;
        end else if (armed) begin
          state_d = START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          if (rx_s == 1'b0) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx] = rx_s;
          if (bit_idx == LAST_BIT) state_d = STOP;
          else bit_idx_d = bit_idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s == IDLE_LEVEL) begin
            data_d  = shift;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: frames are driven on rx and every valid /
// frame_err strobe is compared against times and bytes derived from the frame.
module tb_receiver;

  localparam int C = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  receiver #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         t;
    bit         err;
    logic [7:0] d;
  } ev_t;

  ev_t act[$];
  bit  both_seen = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] last_good = 8'h00;

  // Records every strobe with the index of the clock edge that would sample it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid)              act.push_back('{cyc + 1, 1'b0, data});
      if (frame_err)          act.push_back('{cyc + 1, 1'b1, data});
      if (valid && frame_err) both_seen = 1'b1;
    end
  end

  // Edge at which the strobe for a frame whose start bit first hits the pin
  // at edge t0 becomes visible: stop sample (t0+2+C/2+9C) plus one.
  function automatic int strobe_time(input int t0);
    return t0 + 2 + C / 2 + 9 * C + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc + 1;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = stop;
    tick(C);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++;
    if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else n_pass++;
    n_checks++;
    if (valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset_strobes got valid=%b frame_err=%b exp=0/0", valid, frame_err);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    rst_n = 1'b1;
    tick(2 * C);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_good_byte();
    int t0;
    act.delete();
    send_frame(8'hA5, 1'b1, t0);
    last_good = 8'hA5;
    tick(C);
    n_checks++;
    if (act.size() != 1) $display("FAIL good_count got=%0d exp=1", act.size()); else n_pass++;
    if (act.size() > 0) begin
      n_checks++;
      if (act[0].t != strobe_time(t0) || act[0].err !== 1'b0)
        $display("FAIL good_timing got t=%0d err=%b exp t=%0d err=0",
                 act[0].t - t0, act[0].err, strobe_time(t0) - t0);
      else n_pass++;
    end
    n_checks++;
    if (data !== 8'hA5) $display("FAIL good_data got=%h exp=a5", data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    act.delete();
    send_frame(8'h00, 1'b1, ta);
    send_frame(8'hFF, 1'b1, tb);
    last_good = 8'hFF;
    tick(C);
    n_checks++;
    if (act.size() != 2) $display("FAIL b2b_count got=%0d exp=2", act.size()); else n_pass++;
    if (act.size() == 2) begin
      n_checks++;
      if (act[0].d !== 8'h00 || act[1].d !== 8'hFF || act[0].err || act[1].err)
        $display("FAIL b2b_data got=%h,%h exp=00,ff", act[0].d, act[1].d);
      else n_pass++;
      n_checks++;
      if (act[0].t != strobe_time(ta) || act[1].t - act[0].t != 10 * C)
        $display("FAIL b2b_spacing got=%0d exp=%0d", act[1].t - act[0].t, 10 * C);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    act.delete();
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (busy) busy_cycles++;
    end
    rx = 1'b1;
    for (int i = 0; i < 3 * C; i++) begin
      tick(1);
      if (busy) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles < 1 || busy_cycles > 8)
      $display("FAIL glitch_busy got=%0d exp=1..8", busy_cycles);
    else n_pass++;
    n_checks++;
    if (act.size() != 0) $display("FAIL glitch_strobes got=%0d exp=0", act.size()); else n_pass++;
    n_checks++;
    if (data !== last_good) $display("FAIL glitch_data got=%h exp=%h", data, last_good); else n_pass++;
  endtask

  task automatic test_bad_stop();
    int t0;
    act.delete();
    send_frame(8'h3C, 1'b0, t0);
    tick(C);
    n_checks++;
    if (act.size() != 1) $display("FAIL badstop_count got=%0d exp=1", act.size()); else n_pass++;
    if (act.size() > 0) begin
      n_checks++;
      if (act[0].err !== 1'b1 || act[0].t != strobe_time(t0))
        $display("FAIL badstop_err got err=%b t=%0d exp err=1 t=%0d",
                 act[0].err, act[0].t - t0, strobe_time(t0) - t0);
      else n_pass++;
    end
    n_checks++;
    if (data !== last_good) $display("FAIL badstop_data got=%h exp=%h", data, last_good); else n_pass++;
  endtask

  task automatic test_break();
    int t0, t1;
    act.delete();
    t0 = cyc + 1;
    rx = 1'b0;
    tick(40 * C);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL break_busy got=%b exp=0", busy); else n_pass++;
    rx = 1'b1;
    tick(2 * C);
    send_frame(8'h5A, 1'b1, t1);
    last_good = 8'h5A;
    tick(C);
    n_checks++;
    if (act.size() != 2) $display("FAIL break_count got=%0d exp=2", act.size()); else n_pass++;
    if (act.size() == 2) begin
      n_checks++;
      if (!act[0].err || act[0].t != strobe_time(t0))
        $display("FAIL break_err got err=%b t=%0d exp err=1 t=%0d",
                 act[0].err, act[0].t - t0, strobe_time(t0) - t0);
      else n_pass++;
      n_checks++;
      if (act[1].err || act[1].d !== 8'h5A || act[1].t != strobe_time(t1))
        $display("FAIL break_recover got=%h err=%b exp=5a err=0", act[1].d, act[1].err);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    logic [7:0] b = 8'h96;
    act.delete();
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = b[3];
    tick(C / 2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_outputs got data=%h v=%b fe=%b busy=%b exp 00/0/0/0",
               data, valid, frame_err, busy);
    else n_pass++;
    last_good = 8'h00;
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * C);
    send_frame(8'h81, 1'b1, t0);
    last_good = 8'h81;
    tick(C);
    n_checks++;
    if (act.size() != 1) $display("FAIL midreset_count got=%0d exp=1", act.size()); else n_pass++;
    n_checks++;
    if (data !== 8'h81) $display("FAIL midreset_data got=%h exp=81", data); else n_pass++;
  endtask

  task automatic test_random();
    ev_t exp_q[$];
    int  t0;
    act.delete();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b    = 8'($urandom());
      logic       stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, t0);
      if (stop) last_good = b;
      exp_q.push_back('{strobe_time(t0), !stop, last_good});
      // After a bad stop the line must be seen high before a new start counts.
      tick(stop ? $urandom_range(0, C) : $urandom_range(2, C));
    end
    tick(C);
    n_checks++;
    if (act.size() != exp_q.size())
      $display("FAIL rand_count got=%0d exp=%0d", act.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < act.size(); i++) begin
      n_checks++;
      if (act[i].t != exp_q[i].t || act[i].err !== exp_q[i].err || act[i].d !== exp_q[i].d)
        $display("FAIL rand_frame%0d got t=%0d err=%b d=%h exp t=%0d err=%b d=%h", i,
                 act[i].t, act[i].err, act[i].d, exp_q[i].t, exp_q[i].err, exp_q[i].d);
      else n_pass++;
    end
    n_checks++;
    if (both_seen) $display("FAIL strobe_exclusive got=1 exp=0"); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_back_to_back();
    test_glitch();
    test_bad_stop();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

- Serial-to-parallel UART receiver: recovers 8N1 frames from an asynchronous `rx` line and presents each byte on a parallel bus with a one-cycle `valid` strobe.
- Downstream counterpart of the UART transmitter on the far end of the link; its output feeds a consumer (CPU or FIFO).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit recovery is oversampled: one sample at mid-bit, timed by a clock-cycle counter.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Legal values ≥ 4.
- `clk` input 1: single clock. All logic is posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous to `clk`. Idles high.
- `data` output 8: last correctly received byte. Holds until the next good frame.
- `valid` output 1: one-cycle pulse when `data` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled 0.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Only `rx_s` is used internally.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, counters=0, synchronizer flops=1, `armed`=0.
- `armed` is set whenever `rx_s`=1 is seen in IDLE. It prevents a held-low line (break) from retriggering.
- State machine:
  - IDLE → START when `rx_s`=0 and `armed`=1. On this transition: clear `cnt` and clear `armed`.
  - START: `cnt` counts up to `CLKS_PER_BIT/2 - 1` (integer division), then `rx_s` is sampled (mid start bit).
    - Sample 0: go to DATA with `cnt`=0, `bit_idx`=0.
    - Sample 1: glitch; return to IDLE with no output.
  - DATA: `cnt` counts up to `CLKS_PER_BIT - 1`, then `rx_s` is sampled.
    - Sampled bit goes into `shift[bit_idx]`.
    - At `bit_idx`=7, go to STOP; otherwise increment `bit_idx`.
    - `cnt` wraps to 0 after each sample.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - Sample 1: `data`←`shift` and pulse `valid`.
    - Sample 0: pulse `frame_err`; `data` is unchanged.
    - Either way, go to IDLE.
- `cnt` width is `$clog2(CLKS_PER_BIT)`. `bit_idx` is 3 bits. All compares are exact equality; counters never saturate.
- `valid` and `frame_err` are never high in the same cycle. Neither stays high for more than one cycle.
- No backpressure: the consumer must take `data` on or after `valid`. A later good frame overwrites it.
- Asserting `rst_n` low mid-frame discards the partial byte immediately. The next frame after release is received normally.

## Timing
- Let t0 be the first posedge at which the `rx` pin is 0. Then:
  - `rx_s`=0 at t0+2; START is entered at t0+3.
  - Start-bit sample at t0+2+⌊C/2⌋.
  - Data bit k is sampled C·(k+1) cycles after the start-bit sample.
  - Stop-bit sample at t0+2+⌊C/2⌋+9C.
- `valid` or `frame_err` is high in the cycle after the stop-bit sample. For C=16 that is t0+155.
- After a good stop bit, IDLE can accept a new start edge on the next cycle. Back-to-back frames with no idle gap are received.
- Sampling tolerates ±(C/2−1)/C bit-period drift accumulated over a frame.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP as a 2-bit enum);
  - `DATA_BITS`=8;
  - `IDLE_LEVEL`=1'b1.
  - The transmitter uses the same package.
- Sub-module `sync2`: 2-flop synchronizer with asynchronous active-low reset to a parameterised value (1 here).
- Everything else stays in `receiver`: FSM, counters, shift register.

## Test plan
- Good byte: C=16, drive 0xA5 framed → `data`=0xA5, `valid` high for exactly one cycle at t0+155, `frame_err` stays 0.
- Back-to-back frames: 0x00 then 0xFF with no gap → two `valid` pulses 160 cycles apart, `data`=0x00 then 0xFF.
- Glitch: `rx` low for 4 cycles, then high → FSM returns to IDLE, no `valid`, no `frame_err`, `busy` is high for ≤ 8 cycles only.
- Bad stop bit: frame of 0x3C with stop bit=0 → `frame_err` pulses once, `data` keeps its prior value (0xFF).
- Break: `rx` held low for 40 bit times → exactly one `frame_err`, no further activity until `rx` returns high; then 0x5A is received correctly.
- Reset mid-frame: assert `rst_n` low during data bit 3 → all outputs go to reset values asynchronously; after release, 0x81 is received correctly.
